// File: rtl/mdu_ctrl_pkg.sv
// Shared encodings for the multiply/divide sequencer: operation codes, FSM states
// and small decode helpers used by the control block.
package mdu_ctrl_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'd0,
    MDU_MULTU = 2'd1,
    MDU_DIV   = 2'd2,
    MDU_DIVU  = 2'd3
  } mdu_op_e;

  typedef enum logic [2:0] {
    MDU_IDLE    = 3'd0,
    MDU_MUL     = 3'd1,
    MDU_DIV_RUN = 3'd2,
    MDU_FIX     = 3'd3,
    MDU_DZERO   = 3'd4,
    MDU_DONE    = 3'd5
  } mdu_state_e;

  function automatic logic opIsDiv(input mdu_op_e o);
    return (o == MDU_DIV) || (o == MDU_DIVU);
  endfunction

  function automatic logic opIsSigned(input mdu_op_e o);
    return (o == MDU_MULT) || (o == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_div_core.sv
// One restoring division step on magnitudes: shift the partial remainder left by one
// dividend bit, trial-subtract the divisor and keep the difference only if it did not borrow.
module mdu_div_core #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quot_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quot_o
);

  logic [WIDTH:0] remShift;
  logic [WIDTH:0] trial;

  // The partial remainder stays below the divisor, so the shifted value fits in WIDTH+1
  // bits and the top bit of the trial difference is a clean borrow flag.
  always_comb begin
    remShift = {rem_i, quot_i[WIDTH-1]};
    trial    = remShift - {1'b0, divisor_i};
    if (!trial[WIDTH]) begin
      rem_o  = trial[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o  = remShift[WIDTH-1:0];
      quot_o = {quot_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: latches operands on start, stalls the pipe
// while busy and writes {hi,lo} with a one-cycle done pulse.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (WIDTH > MUL_LATENCY) ? WIDTH : MUL_LATENCY;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int CHAIN   = (MUL_LATENCY > 1) ? MUL_LATENCY - 1 : 1;

  mdu_state_e       state_q;
  mdu_op_e          op_q;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] divisor_q;
  logic             negQuot_q;
  logic             negRem_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [2*WIDTH-1:0] prodChain_q [CHAIN];
  logic [2*WIDTH-1:0] prod_d;
  logic [2*WIDTH-1:0] prodFinal;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH-1:0]   quot_d;
  logic [WIDTH-1:0]   quotFixed;
  logic [WIDTH-1:0]   remFixed;
  logic [WIDTH-1:0]   aMag;
  logic [WIDTH-1:0]   bMag;
  logic               reqSigned;
  logic               aNeg;
  logic               bNeg;
  logic               mulSigned;
  logic               idleOrDone;
  logic               busy;

  mdu_div_core #(
    .WIDTH(WIDTH)
  ) u_div_core (
    .rem_i    (rem_q),
    .quot_i   (quot_q),
    .divisor_i(divisor_q),
    .rem_o    (rem_d),
    .quot_o   (quot_d)
  );

  // Stall is combinational from start so the instruction holds in EX on the accept cycle;
  // it drops in DONE so EX advances together with the done pulse.
  always_comb begin
    idleOrDone = (state_q == MDU_IDLE) || (state_q == MDU_DONE);
    busy       = (state_q == MDU_MUL) || (state_q == MDU_DIV_RUN) ||
                 (state_q == MDU_FIX) || (state_q == MDU_DZERO);
    stall      = busy || (start && idleOrDone && !flush);

    reqSigned = opIsSigned(mdu_op_e'(op));
    aNeg      = reqSigned && src_a[WIDTH-1];
    bNeg      = reqSigned && src_b[WIDTH-1];
    aMag      = aNeg ? -src_a : src_a;
    bMag      = bNeg ? -src_b : src_b;

    mulSigned = (op_q == MDU_MULT);
    prod_d    = {{WIDTH{mulSigned && a_q[WIDTH-1]}}, a_q} *
                {{WIDTH{mulSigned && b_q[WIDTH-1]}}, b_q};

    quotFixed = negQuot_q ? -quot_q : quot_q;
    remFixed  = negRem_q ? -rem_q : rem_q;
  end

  // hi/lo form the last product stage, so MUL_LATENCY-1 chain registers precede them.
  if (MUL_LATENCY > 1) begin : gChain
    assign prodFinal = prodChain_q[CHAIN-1];
  end else begin : gNoChain
    assign prodFinal = prod_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CHAIN; i++) prodChain_q[i] <= '0;
    end else if (state_q == MDU_MUL) begin
      prodChain_q[0] <= prod_d;
      for (int i = 1; i < CHAIN; i++) prodChain_q[i] <= prodChain_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= MDU_IDLE;
      op_q      <= MDU_MULT;
      count_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rem_q     <= '0;
      quot_q    <= '0;
      divisor_q <= '0;
      negQuot_q <= 1'b0;
      negRem_q  <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q <= 1'b0;
      if (flush) begin
        state_q <= MDU_IDLE;
      end else begin
        case (state_q)
          MDU_IDLE, MDU_DONE: begin
            if (start) begin
              op_q      <= mdu_op_e'(op);
              a_q       <= src_a;
              b_q       <= src_b;
              count_q   <= '0;
              rem_q     <= '0;
              quot_q    <= aMag;
              divisor_q <= bMag;
              negQuot_q <= aNeg ^ bNeg;
              negRem_q  <= aNeg;
              if (!opIsDiv(mdu_op_e'(op)))
                state_q <= MDU_MUL;
              else if (src_b == '0)
                state_q <= MDU_DZERO;
              else
                state_q <= MDU_DIV_RUN;
            end else begin
              state_q <= MDU_IDLE;
            end
          end
          MDU_MUL: begin
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(MUL_LATENCY - 1)) begin
              hi_q    <= prodFinal[2*WIDTH-1:WIDTH];
              lo_q    <= prodFinal[WIDTH-1:0];
              done_q  <= 1'b1;
              state_q <= MDU_DONE;
            end
          end
          MDU_DIV_RUN: begin
            rem_q   <= rem_d;
            quot_q  <= quot_d;
            count_q <= count_q + 1'b1;
            if (count_q == CNT_W'(WIDTH - 1))
              state_q <= MDU_FIX;
          end
          MDU_FIX: begin
            hi_q    <= remFixed;
            lo_q    <= quotFixed;
            done_q  <= 1'b1;
            state_q <= MDU_DONE;
          end
          MDU_DZERO: begin
            hi_q    <= a_q;
            lo_q    <= '1;
            done_q  <= 1'b1;
            state_q <= MDU_DONE;
          end
          default: state_q <= MDU_IDLE;
        endcase
      end
    end
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
